// File: rtl/pa_lsu_sram_pkg.sv
// Shared types and constants for the LSU SRAM arbiter: FSM states, default geometry,
// requester ids and the 2-way round-robin pick used by the arbiter.
package pa_lsu_sram_pkg;

   localparam int AW_DEF = 10;
   localparam int DW_DEF = 36;

   typedef enum logic {
      ST_CLR  = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

   localparam logic RID_R0 = 1'b0;
   localparam logic RID_R1 = 1'b1;

   // One-hot grant for two requesters; ptr names the side that wins a tie.
   function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic ptr);
      logic [1:0] g;
      g = 2'b00;
      if (req[0] && (!req[1] || ptr == RID_R0)) begin
         g = 2'b01;
      end else if (req[1]) begin
         g = 2'b10;
      end
      return g;
   endfunction

endpackage

// File: rtl/pa_lsu_sram_arb_if.sv
// Requester, clear-control and SRAM macro signals of the LSU SRAM arbiter.
// slave = arbiter side; master = requesters plus the SRAM macro.
interface pa_lsu_sram_arb_if
   import pa_lsu_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = AW_DEF,
   parameter int DATA_WIDTH = DW_DEF
);

   logic                  clr_req;
   logic                  clr_busy;

   logic                  r0_req;
   logic                  r0_wr;
   logic [ADDR_WIDTH-1:0] r0_addr;
   logic [DATA_WIDTH-1:0] r0_wdata;
   logic [DATA_WIDTH-1:0] r0_wmask;
   logic                  r0_gnt;
   logic                  r0_rvld;

   logic                  r1_req;
   logic                  r1_wr;
   logic [ADDR_WIDTH-1:0] r1_addr;
   logic [DATA_WIDTH-1:0] r1_wdata;
   logic [DATA_WIDTH-1:0] r1_wmask;
   logic                  r1_gnt;
   logic                  r1_rvld;

   logic [DATA_WIDTH-1:0] rdata;

   logic [ADDR_WIDTH-1:0] sram_a;
   logic                  sram_cen;
   logic                  sram_gwen;
   logic [DATA_WIDTH-1:0] sram_wen;
   logic [DATA_WIDTH-1:0] sram_d;
   logic [DATA_WIDTH-1:0] sram_q;

   modport slave (
      input  clr_req,
      input  r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
      input  r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
      input  sram_q,
      output clr_busy,
      output r0_gnt, r0_rvld, r1_gnt, r1_rvld, rdata,
      output sram_a, sram_cen, sram_gwen, sram_wen, sram_d
   );

   modport master (
      output clr_req,
      output r0_req, r0_wr, r0_addr, r0_wdata, r0_wmask,
      output r1_req, r1_wr, r1_addr, r1_wdata, r1_wmask,
      output sram_q,
      input  clr_busy,
      input  r0_gnt, r0_rvld, r1_gnt, r1_rvld, rdata,
      input  sram_a, sram_cen, sram_gwen, sram_wen, sram_d
   );

endinterface

// File: rtl/pa_lsu_sram_rr_arb.sv
// 2-way round-robin arbiter: combinational grant in the request cycle, no grant when en_i=0.
// After any grant the pointer moves to the other requester so a held tie alternates.
module pa_lsu_sram_rr_arb
   import pa_lsu_sram_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [1:0] req_i,
   input  logic       en_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         gnt_o = rr_pick(req_i, ptr_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         ptr_q <= RID_R0;
      end else if (gnt_o[0]) begin
         ptr_q <= RID_R1;
      end else if (gnt_o[1]) begin
         ptr_q <= RID_R0;
      end
   end

endmodule

// File: rtl/pa_lsu_sram_arb.sv
// Single-port LSU SRAM controller: zero-fill engine after reset/clr_req, round-robin r0/r1 access.
// Grants and SRAM drive are same-cycle; read data returns one cycle after grant; no grants while clearing.
module pa_lsu_sram_arb
   import pa_lsu_sram_pkg::*;
#(
   parameter int ADDR_WIDTH = AW_DEF,
   parameter int DATA_WIDTH = DW_DEF
) (
   input logic              forever_cpuclk,
   input logic              cpurst_b,
   pa_lsu_sram_arb_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

   state_e                state_q;
   logic [ADDR_WIDTH-1:0] clr_cnt_q;
   logic                  clr_busy_q;

   logic [1:0]            req;
   logic [1:0]            gnt;
   logic                  arb_en;
   logic                  acc_vld;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [DATA_WIDTH-1:0] sel_wmask;

   logic                  cen_d;
   logic                  gwen_d;
   logic [DATA_WIDTH-1:0] wen_d;
   logic [ADDR_WIDTH-1:0] a_d, a_q;
   logic [DATA_WIDTH-1:0] d_d, d_q;

   logic                  rd_pend_q;
   logic                  rd_id_q;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

   // clr_req takes the cycle: the arbiter is muted so a colliding request simply waits.
   assign req    = {bus.r1_req, bus.r0_req};
   assign arb_en = cpurst_b && (state_q == ST_IDLE) && !bus.clr_req;

   pa_lsu_sram_rr_arb u_rr_arb (
      .clk_i   (forever_cpuclk),
      .rst_n_i (cpurst_b),
      .req_i   (req),
      .en_i    (arb_en),
      .gnt_o   (gnt)
   );

   assign acc_vld   = |gnt;
   assign sel_wr    = gnt[1] ? bus.r1_wr    : bus.r0_wr;
   assign sel_addr  = gnt[1] ? bus.r1_addr  : bus.r0_addr;
   assign sel_wdata = gnt[1] ? bus.r1_wdata : bus.r0_wdata;
   assign sel_wmask = gnt[1] ? bus.r1_wmask : bus.r0_wmask;

   assign bus.r0_gnt   = gnt[0];
   assign bus.r1_gnt   = gnt[1];
   assign bus.clr_busy = clr_busy_q;

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q    <= ST_CLR;
         clr_cnt_q  <= '0;
         clr_busy_q <= 1'b1;
      end else if (state_q == ST_CLR) begin
         if (bus.clr_req) begin
            clr_cnt_q <= '0;
         end else begin
            clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == CLR_LAST) begin
               state_q    <= ST_IDLE;
               clr_busy_q <= 1'b0;
            end
         end
      end else if (bus.clr_req) begin
         state_q    <= ST_CLR;
         clr_cnt_q  <= '0;
         clr_busy_q <= 1'b1;
      end
   end

   // Macro is kept deselected while reset is held; A/D park on their last value when idle.
   always_comb begin
      cen_d  = 1'b1;
      gwen_d = 1'b1;
      wen_d  = '1;
      a_d    = a_q;
      d_d    = d_q;
      if (cpurst_b) begin
         if (state_q == ST_CLR) begin
            cen_d  = 1'b0;
            gwen_d = 1'b0;
            wen_d  = '0;
            a_d    = clr_cnt_q;
            d_d    = '0;
         end else if (acc_vld) begin
            cen_d = 1'b0;
            a_d   = sel_addr;
            if (sel_wr) begin
               gwen_d = 1'b0;
               wen_d  = ~sel_wmask;
               d_d    = sel_wdata;
            end
         end
      end
   end

   assign bus.sram_cen  = cen_d;
   assign bus.sram_gwen = gwen_d;
   assign bus.sram_wen  = wen_d;
   assign bus.sram_a    = a_d;
   assign bus.sram_d    = d_d;

   // Q is only meaningful in the cycle after a read; rdata_q keeps it afterwards.
   assign rd_pend     = rd_pend_q && cpurst_b;
   assign rdata_d     = rd_pend ? bus.sram_q : rdata_q;
   assign bus.rdata   = rdata_d;
   assign bus.r0_rvld = rd_pend && (rd_id_q == RID_R0);
   assign bus.r1_rvld = rd_pend && (rd_id_q == RID_R1);

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rd_pend_q <= 1'b0;
         rd_id_q   <= RID_R0;
         rdata_q   <= '0;
         a_q       <= '0;
         d_q       <= '0;
      end else begin
         rd_pend_q <= acc_vld && !sel_wr;
         if (acc_vld) begin
            rd_id_q <= gnt[1] ? RID_R1 : RID_R0;
         end
         rdata_q <= rdata_d;
         a_q     <= a_d;
         d_q     <= d_d;
      end
   end

endmodule

// File: tb/tb_pa_lsu_sram_arb.sv
// Directed bench for pa_lsu_sram_arb with a behavioural 1024x36 bit-writable SRAM model.
module tb_pa_lsu_sram_arb;
   import pa_lsu_sram_pkg::*;

   localparam int AW = 10;
   localparam int DW = 36;
   localparam logic [DW-1:0] ONES = '1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pa_lsu_sram_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   pa_lsu_sram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_n),
      .bus            (bus)
   );

   // Array starts non-zero so the clear engine has something visible to do.
   logic [DW-1:0] mem [0:(1<<AW)-1] = '{default: 36'h9_DEAD_BEEF};
   logic [DW-1:0] q_q = '1;
   always @(posedge clk) begin
      if (!bus.sram_cen) begin
         if (!bus.sram_gwen) mem[bus.sram_a] <= (mem[bus.sram_a] & bus.sram_wen) | (bus.sram_d & ~bus.sram_wen);
         else                q_q <= mem[bus.sram_a];
      end
   end
   assign bus.sram_q = q_q;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int busy, writes, bad, found;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic count_clear(output int n_busy, output int n_wr, output int n_bad);
      int exp_a;
      exp_a = 0; n_busy = 0; n_wr = 0; n_bad = 0;
      for (int i = 0; i < 1100; i++) begin
         if (!bus.clr_busy) break;
         n_busy++;
         if (!bus.sram_cen && !bus.sram_gwen && bus.sram_wen == '0 && bus.sram_d == '0 && int'(bus.sram_a) == exp_a) begin
            n_wr++;
            exp_a++;
         end
         if (bus.r0_gnt || bus.r1_gnt || bus.r0_rvld || bus.r1_rvld) n_bad++;
         @(negedge clk); #1;
      end
   endtask

   // Single uncontended access from IDLE: grant and SRAM drive this cycle, rvld/rdata next cycle.
   task automatic access(input bit id, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                         input logic [DW-1:0] exp_rd, input string tag);
      logic [DW-1:0] exp_wen;
      exp_wen = wr ? ~wm : ONES;
      if (id == 1'b0) begin
         bus.r0_req = 1'b1; bus.r0_wr = wr; bus.r0_addr = addr; bus.r0_wdata = wd; bus.r0_wmask = wm;
      end else begin
         bus.r1_req = 1'b1; bus.r1_wr = wr; bus.r1_addr = addr; bus.r1_wdata = wd; bus.r1_wmask = wm;
      end
      #1;
      chk({tag, "_gnt"},   id ? bus.r1_gnt : bus.r0_gnt, 1);
      chk({tag, "_ogn"},   id ? bus.r0_gnt : bus.r1_gnt, 0);
      chk({tag, "_cen"},   bus.sram_cen, 0);
      chk({tag, "_a"},     bus.sram_a, addr);
      chk({tag, "_gwen"},  bus.sram_gwen, !wr);
      chk({tag, "_wen"},   bus.sram_wen, exp_wen);
      if (wr) chk({tag, "_d"}, bus.sram_d, wd);
      @(negedge clk);
      bus.r0_req = 1'b0; bus.r1_req = 1'b0;
      #1;
      chk({tag, "_rvld"},  id ? bus.r1_rvld : bus.r0_rvld, !wr);
      chk({tag, "_orvld"}, id ? bus.r0_rvld : bus.r1_rvld, 0);
      if (!wr) chk({tag, "_rdata"}, bus.rdata, exp_rd);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout passed=%0d total=%0d", passes, checks);
      $fatal(1, "bench did not finish");
   end

   initial begin
      bus.clr_req = 1'b0;
      bus.r0_req = 1'b1; bus.r0_wr = 1'b0; bus.r0_addr = '0; bus.r0_wdata = '0; bus.r0_wmask = '0;
      bus.r1_req = 1'b0; bus.r1_wr = 1'b0; bus.r1_addr = '0; bus.r1_wdata = '0; bus.r1_wmask = '0;

      // Reset state, with r0 requesting to show reset blocks grants
      repeat (3) @(negedge clk);
      #1;
      chk("rst_clr_busy", bus.clr_busy, 1);
      chk("rst_cen",      bus.sram_cen, 1);
      chk("rst_gwen",     bus.sram_gwen, 1);
      chk("rst_wen",      bus.sram_wen, ONES);
      chk("rst_r0_gnt",   bus.r0_gnt, 0);
      chk("rst_r1_gnt",   bus.r1_gnt, 0);
      chk("rst_r0_rvld",  bus.r0_rvld, 0);
      chk("rst_r1_rvld",  bus.r1_rvld, 0);
      chk("rst_rdata",    bus.rdata, 0);
      bus.r0_req = 1'b0;

      // Test 1: full clear after reset release
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      count_clear(busy, writes, bad);
      chk("t1_busy_cycles", busy, 1024);
      chk("t1_zero_writes", writes, 1024);
      chk("t1_no_gnt_in_clr", bad, 0);

      // Test 4: both requesters read for 4 cycles from reset pointer -> r0,r1,r0,r1
      @(negedge clk);
      bus.r0_req = 1'b1; bus.r0_wr = 1'b0; bus.r0_addr = 10'h010;
      bus.r1_req = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = 10'h020;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) begin
            bus.r0_req = 1'b0; bus.r1_req = 1'b0;
         end
         #1;
         chk("t4_r0_gnt", bus.r0_gnt, (k < 4) && (k % 2 == 0));
         chk("t4_r1_gnt", bus.r1_gnt, (k < 4) && (k % 2 == 1));
         if (k < 4) chk("t4_sram_a", bus.sram_a, (k % 2 == 0) ? 10'h010 : 10'h020);
         chk("t4_r0_rvld", bus.r0_rvld, (k > 0) && ((k - 1) % 2 == 0));
         chk("t4_r1_rvld", bus.r1_rvld, (k > 0) && ((k - 1) % 2 == 1));
         if (k > 0) chk("t4_rdata", bus.rdata, 0);
         @(negedge clk);
      end

      access(1'b1, 1'b0, 10'h2AB, '0, '0, 36'h0_0000_0000, "t1_rd");

      // Test 2: r0 writes, r1 reads back
      access(1'b0, 1'b1, 10'h155, 36'hA_5A5A_5A5A, ONES, '0, "t2_wr");
      access(1'b1, 1'b0, 10'h155, '0, '0, 36'hA_5A5A_5A5A, "t2_rd");

      // Test 3: bit-masked write
      access(1'b0, 1'b1, 10'h3FF, 36'hF_FFFF_FFFF, ONES, '0, "t3_wr1");
      access(1'b0, 1'b1, 10'h3FF, 36'h0_0000_0000, 36'h0_0000_00FF, '0, "t3_wr2");
      access(1'b1, 1'b0, 10'h3FF, '0, '0, 36'hF_FFFF_FF00, "t3_rd");
      chk("idle_cen",  bus.sram_cen, 1);
      chk("idle_gwen", bus.sram_gwen, 1);
      chk("idle_wen",  bus.sram_wen, ONES);
      chk("idle_a_hold", bus.sram_a, 10'h3FF);

      // Test 5: clr_req collides with r0_req right after a read grant
      bus.r0_req = 1'b1; bus.r0_wr = 1'b0; bus.r0_addr = 10'h155;
      #1;
      chk("t5_first_gnt", bus.r0_gnt, 1);
      @(negedge clk);
      bus.clr_req = 1'b1;
      #1;
      chk("t5_no_gnt",   bus.r0_gnt, 0);
      chk("t5_rvld",     bus.r0_rvld, 1);
      chk("t5_rdata",    bus.rdata, 36'hA_5A5A_5A5A);
      @(negedge clk);
      bus.clr_req = 1'b0;
      #1;
      chk("t5_busy", bus.clr_busy, 1);
      count_clear(busy, writes, bad);
      chk("t5_busy_cycles", busy, 1024);
      chk("t5_zero_writes", writes, 1024);
      chk("t5_no_gnt_in_clr", bad, 0);
      chk("t5_held_gnt", bus.r0_gnt, 1);
      chk("t5_held_a",   bus.sram_a, 10'h155);
      @(negedge clk);
      bus.r0_req = 1'b0;
      #1;
      chk("t5_rd_rvld",  bus.r0_rvld, 1);
      chk("t5_rd_rdata", bus.rdata, 0);

      // Test 6: reset at clr_cnt=500 restarts the clear from entry 0
      access(1'b1, 1'b1, 10'h200, 36'h1_2345_6789, ONES, '0, "t6_wr");
      bus.clr_req = 1'b1;
      #1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      #1;
      found = 0;
      for (int i = 0; i < 700; i++) begin
         if (!bus.sram_cen && bus.sram_a == 10'd500) begin
            found = 1;
            break;
         end
         @(negedge clk); #1;
      end
      chk("t6_reach_500", found, 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_cen", bus.sram_cen, 1);
      @(negedge clk); #1;
      chk("t6_rst_busy", bus.clr_busy, 1);
      rst_n = 1'b1;
      #1;
      count_clear(busy, writes, bad);
      chk("t6_busy_cycles", busy, 1024);
      chk("t6_zero_writes", writes, 1024);
      access(1'b0, 1'b0, 10'h200, '0, '0, 36'h0_0000_0000, "t6_rd");

      // Reset right after a read grant drops the pending rvld
      bus.r1_req = 1'b1; bus.r1_wr = 1'b0; bus.r1_addr = 10'h155;
      #1;
      chk("t7_gnt", bus.r1_gnt, 1);
      @(negedge clk);
      bus.r1_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t7_rvld_dropped", bus.r1_rvld, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      count_clear(busy, writes, bad);
      chk("t7_busy_cycles", busy, 1024);
      chk("t7_no_gnt_in_clr", bad, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
